// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_e;

    // Width of the shared cycle counter: enough bits for the longest wait.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reset-clearable two-flop synchronizer for asynchronous status inputs.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with non-blocking assignments so every stage samples its pre-edge input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock supervisor: holds the PLL in reset, qualifies lock, and gates the system reset.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES     = 500,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 7
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               pll_locked,
    input  logic                               relock_req,
    output logic                               pll_rst,
    output logic                               sys_rst_n,
    output logic                               ready,
    output logic                               fault,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lock_lost_cnt
);

    localparam int CW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_d;
    logic [7:0]    lost_d;
    logic          locked_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        retry_d = retry_count;
        lost_d  = lock_lost_cnt;

        if (relock_req) begin
            state_d = RESET_HOLD;
            retry_d = '0;
        end else begin
            unique case (state_q)
                RESET_HOLD: if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
                WAIT_LOCK: begin
                    // A lock seen on the timeout cycle still wins over a retry.
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            state_d = FAULT;
                        end else begin
                            retry_d = retry_count + RW'(1);
                            state_d = RESET_HOLD;
                        end
                    end
                end
                STABLE: begin
                    if (!locked_s)                 state_d = WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        if (lock_lost_cnt != 8'hFF) lost_d = lock_lost_cnt + 8'd1;
                        state_d = RESET_HOLD;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = RESET_HOLD;
            endcase
        end

        // Any entry, including a relock re-entering RESET_HOLD, restarts the shared counter.
        if (state_d != state_q || relock_req) cnt_d = '0;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RESET_HOLD;
            cnt_q         <= '0;
            retry_count   <= '0;
            lock_lost_cnt <= 8'd0;
            pll_rst       <= 1'b1;
            sys_rst_n     <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_count   <= retry_d;
            lock_lost_cnt <= lost_d;
            pll_rst       <= (state_d == RESET_HOLD) || (state_d == FAULT);
            sys_rst_n     <= (state_d == RUN);
            ready         <= (state_d == RUN);
            fault         <= (state_d == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomized scoreboard bench for pll_lock_sequencer using a deadline-based reference model.
module tb_pll_lock_sequencer;

    localparam int H = 4;
    localparam int T = 20;
    localparam int L = 8;
    localparam int R = 2;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_lost_cnt;

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES     (H),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (L),
        .MAX_RETRIES         (R)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_count   (retry_count),
        .lock_lost_cnt (lock_lost_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_rst_n;
        logic       ready;
        logic       fault;
        logic [1:0] retry;
        logic [7:0] lost;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: phases with absolute-edge deadlines; lock seen through a sample history.
    typedef enum {M_HOLD, M_WAIT, M_STABLE, M_RUN, M_FAULT} ph_t;
    ph_t  ph;
    int   n;
    int   deadline;
    int   rst_edge;
    int   m_retry;
    int   m_lost;
    logic lk_hist[$];

    function automatic exp_t model_out();
        exp_t e;
        e.pll_rst   = (ph == M_HOLD) || (ph == M_FAULT);
        e.sys_rst_n = (ph == M_RUN);
        e.ready     = (ph == M_RUN);
        e.fault     = (ph == M_FAULT);
        e.retry     = 2'(m_retry);
        e.lost      = 8'(m_lost);
        return e;
    endfunction

    task automatic enter(input ph_t p);
        ph = p;
        case (p)
            M_HOLD:   deadline = n + H;
            M_WAIT:   deadline = n + T;
            M_STABLE: deadline = n + L;
            default:  deadline = -1;
        endcase
    endtask

    task automatic model_reset();
        enter(M_HOLD);
        rst_edge = n;
        m_retry  = 0;
        m_lost   = 0;
    endtask

    task automatic model_edge();
        logic ls;
        n++;
        if (!rst_n) begin
            model_reset();
            lk_hist.push_back(1'b0);
        end else begin
            ls = (n - 2 > rst_edge) ? lk_hist[n-2] : 1'b0;
            lk_hist.push_back(pll_locked);
            if (relock_req) begin
                enter(M_HOLD);
                m_retry = 0;
            end else begin
                case (ph)
                    M_HOLD: if (n == deadline) enter(M_WAIT);
                    M_WAIT: begin
                        if (ls) enter(M_STABLE);
                        else if (n == deadline) begin
                            if (m_retry == R) enter(M_FAULT);
                            else begin
                                m_retry++;
                                enter(M_HOLD);
                            end
                        end
                    end
                    M_STABLE: begin
                        if (!ls) enter(M_WAIT);
                        else if (n == deadline) enter(M_RUN);
                    end
                    M_RUN: begin
                        if (!ls) begin
                            if (m_lost < 255) m_lost++;
                            enter(M_HOLD);
                        end
                    end
                    default: ;
                endcase
            end
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: outputs settle after each clock edge and immediately on reset assertion.
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge refclk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act.pll_rst   = pll_rst;
                act.sys_rst_n = sys_rst_n;
                act.ready     = ready;
                act.fault     = fault;
                act.retry     = retry_count;
                act.lost      = lock_lost_cnt;
                total++;
                if (act !== e) begin
                    bad++;
                    if (bad <= 20)
                        $display("FAIL outputs edge=%0d got pll_rst=%b sys_rst_n=%b ready=%b fault=%b retry=%0d lost=%0d want pll_rst=%b sys_rst_n=%b ready=%b fault=%b retry=%0d lost=%0d",
                                 n, act.pll_rst, act.sys_rst_n, act.ready, act.fault, act.retry, act.lost,
                                 e.pll_rst, e.sys_rst_n, e.ready, e.fault, e.retry, e.lost);
                end
            end
        end
    end

    // One clock of stimulus: drive after the falling edge, model the rising edge.
    task automatic step(input logic lk, input logic rq);
        pll_locked = lk;
        relock_req = rq;
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
    endtask

    task automatic async_reset(input int hold);
        #3;
        model_reset();
        exp_q.push_back(model_out());
        rst_n = 1'b0;
        repeat (hold) step(pll_locked, 1'b0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int run_left;
        logic lk;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        n          = 0;
        lk_hist.push_back(1'b0);
        model_reset();

        repeat (3) step(1'b1, 1'b0);
        #3 rst_n = 1'b1;

        // Lock present from the start.
        repeat (40) step(1'b1, 1'b0);
        // In RUN, lock drop for a few cycles, then recovery.
        repeat (5) step(1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b0);

        // Never locks: retries then fault.
        async_reset(2);
        repeat (90) step(1'b0, 1'b0);
        // Relock from fault with lock present.
        step(1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b0);

        // One-cycle glitch landing on STABLE count 5, then recovery.
        step(1'b1, 1'b1);
        for (int i = 1; i <= 40; i++) step((i == 9) ? 1'b0 : 1'b1, 1'b0);

        // Reset mid-STABLE and mid-RUN.
        step(1'b1, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        async_reset(2);
        repeat (20) step(1'b1, 1'b0);
        async_reset(1);
        repeat (20) step(1'b1, 1'b0);

        // Repeated lock losses in RUN drive the loss counter into saturation.
        for (int k = 0; k < 260; k++) begin
            repeat (15) step(1'b1, 1'b0);
            repeat (3) step(1'b0, 1'b0);
        end
        repeat (20) step(1'b1, 1'b0);

        // Randomized lock runs, glitches, relock pulses and resets.
        run_left = 0;
        lk = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            if (run_left == 0) begin
                lk = ~lk;
                run_left = lk ? $urandom_range(1, 40) : $urandom_range(1, 30);
            end
            run_left--;
            if ($urandom_range(0, 399) == 0) async_reset($urandom_range(1, 3));
            step(lk, ($urandom_range(0, 99) == 0));
        end

        repeat (2) @(negedge refclk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock supervisor for the ADC sampling-clock PLL (50 MHz `refclk` in, four 40 MHz phases out). It drives the PLL reset, qualifies `locked` with a synchronizer and a stability window, and releases the downstream system reset only once the phases are trustworthy. Lock timeouts trigger a bounded number of retries before it latches a fault. It runs on `refclk` because PLL outputs are invalid until lock.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, default 500 — `pll_rst` assertion length (10 µs).
- `LOCK_TIMEOUT_CYCLES`, default 50000 — maximum wait for lock (1 ms).
- `LOCK_STABLE_CYCLES`, default 1024 — consecutive locked cycles required before release.
- `MAX_RETRIES`, default 7 — PLL resets after a timeout before `fault`.

Ports:
- `refclk` in 1 — 50 MHz reference; the only clock.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pll_locked` in 1 — PLL `locked`; asynchronous to `refclk`.
- `relock_req` in 1 — one-cycle request to restart acquisition.
- `pll_rst` out 1 — to PLL `rst`, active-high.
- `sys_rst_n` out 1 — downstream reset, active-low.
- `ready` out 1 — clocks valid (state RUN).
- `fault` out 1 — retries exhausted.
- `retry_count` out `$clog2(MAX_RETRIES+1)` — timeouts in the current acquisition.
- `lock_lost_cnt` out 8 — lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to give `locked_s`.
- One shared counter, `cnt`, is cleared on every state entry.
- All outputs are registered and decoded from the next state.
- Reset values: state RESET_HOLD, `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fault`=0, `retry_count`=0, `lock_lost_cnt`=0, `cnt`=0.

States:
- **RESET_HOLD**: `pll_rst`=1. When `cnt`==RST_HOLD_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0.
  - If `locked_s`, go to STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1: if `retry_count`==MAX_RETRIES, go to FAULT; else increment `retry_count` and go to RESET_HOLD.
- **STABLE**:
  - If `!locked_s`, go to WAIT_LOCK. `cnt` restarts and `retry_count` is unchanged.
  - Otherwise, when `cnt`==LOCK_STABLE_CYCLES-1, go to RUN.
- **RUN**: `sys_rst_n`=1, `ready`=1. If `!locked_s`, increment `lock_lost_cnt` (saturating) and go to RESET_HOLD.
- **FAULT**: `pll_rst`=1, `fault`=1. Stays here until `relock_req` or `rst_n`.

Priorities and boundary cases:
- `relock_req` wins in every state: go to RESET_HOLD and clear `retry_count`.
- WAIT_LOCK, `locked_s` on the timeout cycle: STABLE wins.
- STABLE, lock drop on the final count: WAIT_LOCK wins.
- `retry_count` is cleared only by `rst_n` or `relock_req`. It never exceeds MAX_RETRIES.
- `rst_n` assertion in any state, including mid-count, forces all reset values immediately. The synchronizer is also cleared.

## Timing
- Lock change to FSM decision: 2 cycles of synchronizer latency, then the transition on the next edge. A `pll_locked` fall in RUN drops `ready`/`sys_rst_n` on the 3rd edge.
- `pll_rst` stays high for exactly RST_HOLD_CYCLES edges after RESET_HOLD entry or `rst_n` release.
- Lock present from the start: `ready` rises at edge RST_HOLD_CYCLES+1+LOCK_STABLE_CYCLES after `rst_n` release.
- `sys_rst_n` and `ready` always change on the same edge.
- Counter width: `$clog2` of the largest cycle parameter.

## Structure
- `pll_seq_pkg`: state enum (`RESET_HOLD`, `WAIT_LOCK`, `STABLE`, `RUN`, `FAULT`) and the counter-width function.
- Sub-module `sync_2ff`: reset-clearable 2-flop synchronizer, reused for other asynchronous status inputs.

## Test plan
Parameters for all scenarios: RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
- `pll_locked`=1 throughout → `pll_rst` high for 4 edges; `ready`=`sys_rst_n`=1 at edge 13; `retry_count`=0.
- `pll_locked`=0 throughout → 3 `pll_rst` pulses of 4 cycles each, 20 cycles apart; then `fault`=1, `retry_count`=2, `pll_rst` stuck 1, `ready`=0.
- Lock, then a 1-cycle drop at STABLE `cnt`=5 → returns to WAIT_LOCK and `ready` stays 0; after lock returns, `ready` follows 9 edges after the restored `locked_s`.
- In RUN, drop `pll_locked` → `ready`/`sys_rst_n` fall at the 3rd edge; `lock_lost_cnt`=1; `pll_rst` high 4 cycles; `ready` returns after relock.
- From FAULT, pulse `relock_req` → `fault`=0 and `retry_count`=0 next edge; with lock present, `ready` at edge 13 after the pulse.
- Assert `rst_n` mid-STABLE (and mid-RUN) → all outputs at reset values with no clock edge; the sequence restarts on release.
